dnn_stream_host: RTL

- Host-side stream endpoint for the accelerator top. The transmit engine reads 64-bit words from local memory and drives the 4x16-bit src stream (src_valid/ready/last).
- The receive engine accepts the 2x32-bit dst stream (dst_valid/ready/last) and writes it back to local memory.
- Used as the bench/SoC-side initiator of src and responder of dst. The two engines are independent and may run concurrently.

---
 rtl/dnn_stream_host.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dnn_stream_host.sv
// rtl/dnn_stream_host.sv - host-side src stream transmitter and dst stream receiver
// TX prefetches memory words into a small FIFO under read credit; RX writes dst beats back to memory.
module dnn_stream_host #(
    parameter int AW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tx_start,
    input  logic [AW-1:0] tx_base,
    input  logic [12:0]   tx_len,
    output logic          tx_busy,
    output logic          tx_done,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [63:0]   mem_rd_data,
    output logic          src_valid,
    output logic [15:0]   src_data0,
    output logic [15:0]   src_data1,
    output logic [15:0]   src_data2,
    output logic [15:0]   src_data3,
    output logic          src_last,
    input  logic          src_ready,
    input  logic          rx_start,
    input  logic [AW-1:0] rx_base,
    input  logic [12:0]   rx_len,
    output logic          rx_busy,
    output logic          rx_done,
    output logic          rx_err,
    input  logic          dst_valid,
    input  logic [31:0]   dst_data0,
    input  logic [31:0]   dst_data1,
    input  logic          dst_last,
    output logic          dst_ready,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic [63:0]   mem_wr_data
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [0:0]    S_IDLE  = 1'b0;
    localparam logic [0:0]    S_RUN   = 1'b1;
    localparam logic [PW+1:0] DEPTH_C = DEPTH[PW+1:0];

    logic [0:0]    r_tx_state;
    logic [AW-1:0] r_tx_base;
    logic [12:0]   r_tx_len;
    logic [12:0]   r_tx_issued;
    logic [12:0]   r_tx_popped;
    logic          r_tx_done;
    logic          r_rd_pend;
    logic [63:0]   r_fifo [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;

    logic          w_tx_run;
    logic [PW+1:0] w_used;
    logic          w_rd_en;
    logic          w_push;
    logic          w_pop;
    logic          w_src_valid;
    logic [63:0]   w_head;
    logic          w_last_beat;

    // Credit counts the read still in flight so the FIFO can never overflow.
    assign w_tx_run    = (r_tx_state == S_RUN);
    assign w_used      = {1'b0, r_count} + {{(PW + 1){1'b0}}, r_rd_pend};
    assign w_rd_en     = w_tx_run && (r_tx_issued < r_tx_len) && (w_used < DEPTH_C);
    assign w_push      = r_rd_pend;
    assign w_src_valid = (r_count != '0);
    assign w_pop       = w_src_valid && src_ready;
    assign w_head      = r_fifo[r_rptr];
    assign w_last_beat = (r_tx_popped == r_tx_len - 13'd1);

    assign tx_busy     = w_tx_run;
    assign tx_done     = r_tx_done;
    assign mem_rd_en   = w_rd_en;
    assign mem_rd_addr = w_rd_en ? (r_tx_base + AW'(r_tx_issued)) : '0;
    assign src_valid   = w_src_valid;
    assign src_data0   = w_src_valid ? w_head[15:0]  : 16'h0;
    assign src_data1   = w_src_valid ? w_head[31:16] : 16'h0;
    assign src_data2   = w_src_valid ? w_head[47:32] : 16'h0;
    assign src_data3   = w_src_valid ? w_head[63:48] : 16'h0;
    assign src_last    = w_src_valid && w_last_beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state  <= S_IDLE;
            r_tx_base   <= '0;
            r_tx_len    <= '0;
            r_tx_issued <= '0;
            r_tx_popped <= '0;
            r_tx_done   <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
        end else begin
            r_tx_done <= 1'b0;
            r_rd_pend <= w_rd_en;
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
            if (r_tx_state == S_IDLE) begin
                // The done cycle still blocks a new start so the pulse cannot overlap a job.
                if (tx_start && !r_tx_done) begin
                    if (tx_len == 13'd0) begin
                        r_tx_done <= 1'b1;
                    end else begin
                        r_tx_state  <= S_RUN;
                        r_tx_base   <= tx_base;
                        r_tx_len    <= tx_len;
                        r_tx_issued <= '0;
                        r_tx_popped <= '0;
                    end
                end
            end else begin
                if (w_rd_en) r_tx_issued <= r_tx_issued + 13'd1;
                if (w_pop) begin
                    r_tx_popped <= r_tx_popped + 13'd1;
                    if (w_last_beat) begin
                        r_tx_state <= S_IDLE;
                        r_tx_done  <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= mem_rd_data;
    end

    logic [0:0]    r_rx_state;
    logic [AW-1:0] r_rx_base;
    logic [12:0]   r_rx_len;
    logic [12:0]   r_rx_cnt;
    logic          r_rx_done;
    logic          r_rx_err;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [63:0]   r_wr_data;
    logic          w_rx_final;

    assign w_rx_final  = (r_rx_cnt == r_rx_len - 13'd1);
    assign rx_busy     = (r_rx_state == S_RUN);
    assign dst_ready   = (r_rx_state == S_RUN);
    assign rx_done     = r_rx_done;
    assign rx_err      = r_rx_err;
    assign mem_wr_en   = r_wr_en;
    assign mem_wr_addr = r_wr_addr;
    assign mem_wr_data = r_wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= S_IDLE;
            r_rx_base  <= '0;
            r_rx_len   <= '0;
            r_rx_cnt   <= '0;
            r_rx_done  <= 1'b0;
            r_rx_err   <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en   <= 1'b0;
            r_rx_done <= 1'b0;
            if (r_rx_state == S_IDLE) begin
                if (rx_start) begin
                    r_rx_err  <= 1'b0;
                    r_rx_base <= rx_base;
                    r_rx_len  <= rx_len;
                    r_rx_cnt  <= '0;
                    if (rx_len == 13'd0) r_rx_done  <= 1'b1;
                    else                 r_rx_state <= S_RUN;
                end
            end else if (dst_valid) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_rx_base + AW'(r_rx_cnt);
                r_wr_data <= {dst_data1, dst_data0};
                r_rx_cnt  <= r_rx_cnt + 13'd1;
                // Done is registered alongside the final write so both land in the same cycle.
                if (dst_last || w_rx_final) begin
                    r_rx_state <= S_IDLE;
                    r_rx_done  <= 1'b1;
                    r_rx_err   <= (dst_last != w_rx_final);
                end
            end
        end
    end

endmodule
